// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: EX-stage operand forwarding selects, load-use stall
// request and a saturating stall-cycle counter for the five-stage pipeline.
module forward_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ID_Valid_i,
    input  logic [REG_ADDR_W-1:0] ID_RS1_i,
    input  logic [REG_ADDR_W-1:0] ID_RS2_i,
    input  logic [REG_ADDR_W-1:0] ID_RD_i,
    input  logic                  ID_RegWrite_i,
    input  logic                  ID_MemRead_i,
    input  logic                  Flush_i,
    output logic [1:0]            ForwardA_o,
    output logic [1:0]            ForwardB_o,
    output logic                  Stall_o,
    output logic [CNT_W-1:0]      StallCount_o
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_t;

    ex_t                   ex_q;
    ex_t                   ex_d;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  mem_rw_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_rw_q;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic                  stall;

    // MEM result is newer than WB, so it wins when both match; x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_rw,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_rw
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_rw && (m_rd != '0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_rw && (w_rd != '0) && (w_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // load in EX whose destination is read by the real instruction in ID
    always_comb begin
        stall = ID_Valid_i && ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == ID_RS1_i) || (ex_q.rd == ID_RS2_i));
    end

    // operand selects for the instruction currently in EX
    always_comb begin
        ForwardA_o = fwd_sel(ex_q.rs1, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
        ForwardB_o = fwd_sel(ex_q.rs2, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
    end

    // next EX contents: a bubble on flush, stall or empty decode slot
    always_comb begin
        ex_d = '0;
        if (ID_Valid_i && !Flush_i && !stall) begin
            ex_d.rs1       = ID_RS1_i;
            ex_d.rs2       = ID_RS2_i;
            ex_d.rd        = ID_RD_i;
            ex_d.reg_write = ID_RegWrite_i;
            ex_d.mem_read  = ID_MemRead_i;
        end
    end

    // shadow pipeline of destination/write-enable fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q     <= '0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_rd_q <= ex_q.rd;
            mem_rw_q <= ex_q.reg_write;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign Stall_o      = stall;
    assign StallCount_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb_forward_ctrl_unit: directed and randomized checks of forwarding,
// load-use stall and stall counter against an instruction-level model.
module tb_forward_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [15:0] cnt;
    logic [1:0] fa_s;
    logic [1:0] fb_s;
    logic       st_s;
    logic [3:0] cnt_s;

    int nchk;
    int nerr;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        bit         rw;
        bit         mr;
    } ins_t;

    // model: the instructions occupying EX, MEM, WB
    ins_t m_ex;
    ins_t m_mem;
    ins_t m_wb;
    int   m_cnt;
    int   m_cnt_s;

    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic       exp_s;
    int         exp_cnt;
    int         exp_cnt_s;

    forward_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .ID_Valid_i(v),
        .ID_RS1_i(rs1), .ID_RS2_i(rs2), .ID_RD_i(rd),
        .ID_RegWrite_i(rw), .ID_MemRead_i(mr), .Flush_i(fl),
        .ForwardA_o(fa), .ForwardB_o(fb), .Stall_o(st),
        .StallCount_o(cnt)
    );

    forward_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .ID_Valid_i(v),
        .ID_RS1_i(rs1), .ID_RS2_i(rs2), .ID_RD_i(rd),
        .ID_RegWrite_i(rw), .ID_MemRead_i(mr), .Flush_i(fl),
        .ForwardA_o(fa_s), .ForwardB_o(fb_s), .Stall_o(st_s),
        .StallCount_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t bubble();
        ins_t b;
        b = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        return b;
    endfunction

    // newest older writer of a nonzero register supplies the operand
    function automatic logic [1:0] model_fwd(logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (m_mem.rw && m_mem.rd == r) return 2'b10;
        if (m_wb.rw && m_wb.rd == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = bubble();
        m_mem = bubble();
        m_wb = bubble();
        m_cnt = 0;
        m_cnt_s = 0;
    endtask

    // present one instruction at ID for one cycle; expectations for this
    // cycle are left in exp_*, the model then advances past the next edge
    task automatic cyc(input bit iv, input int a, input int b, input int d,
                       input bit w, input bit m, input bit f);
        ins_t n;
        @(negedge clk);
        v = iv;
        rs1 = 5'(a);
        rs2 = 5'(b);
        rd = 5'(d);
        rw = w;
        mr = m;
        fl = f;
        #1;
        exp_a = model_fwd(m_ex.rs1);
        exp_b = model_fwd(m_ex.rs2);
        exp_s = iv && m_ex.mr && m_ex.rd != 0 &&
                (m_ex.rd == 5'(a) || m_ex.rd == 5'(b));
        exp_cnt = m_cnt;
        exp_cnt_s = m_cnt_s;
        n = '{rs1: 5'(a), rs2: 5'(b), rd: 5'(d), rw: w, mr: m};
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = (iv && !f && !exp_s) ? n : bubble();
        if (exp_s) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
        end
    endtask

    task automatic idle_inputs();
        v = 0; rs1 = 0; rs2 = 0; rd = 0; rw = 0; mr = 0; fl = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #2 rst = 1;
        #1;
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00 || st !== 1'b0 || cnt !== 16'd0) begin
            nerr++;
            $display("FAIL reset_async a=%b b=%b s=%b cnt=%0d required 00 00 0 0",
                     fa, fb, st, cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00 || st !== 1'b0 || cnt_s !== 4'd0) begin
            nerr++;
            $display("FAIL reset_held a=%b b=%b s=%b cnt_s=%0d required 00 00 0 0",
                     fa, fb, st, cnt_s);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        cyc(1, 1, 2, 5, 1, 0, 0);
        cyc(1, 5, 6, 10, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b10 || fa !== exp_a) begin
            nerr++;
            $display("FAIL b2b_fwd_a got=%b required=10", fa);
        end
        nchk++;
        if (fb !== 2'b00 || fb !== exp_b) begin
            nerr++;
            $display("FAIL b2b_fwd_b got=%b required=00", fb);
        end
    endtask

    task automatic test_distance2();
        cyc(1, 1, 1, 7, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 7, 11, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fb !== 2'b01 || fa !== 2'b00) begin
            nerr++;
            $display("FAIL dist2_wb got a=%b b=%b required a=00 b=01", fa, fb);
        end
        cyc(1, 1, 1, 7, 1, 0, 0);
        cyc(1, 2, 2, 7, 1, 0, 0);
        cyc(1, 7, 4, 12, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b10 || fb !== 2'b00) begin
            nerr++;
            $display("FAIL prio_mem got a=%b b=%b required a=10 b=00", fa, fb);
        end
    endtask

    task automatic test_load_use();
        int c0;
        cyc(1, 2, 0, 8, 1, 1, 0);
        cyc(1, 8, 6, 9, 1, 0, 0);
        c0 = exp_cnt;
        nchk++;
        if (st !== 1'b1) begin
            nerr++;
            $display("FAIL lu_stall got=%b required=1", st);
        end
        cyc(1, 8, 6, 9, 1, 0, 0);
        nchk++;
        if (st !== 1'b0 || fa !== 2'b00) begin
            nerr++;
            $display("FAIL lu_bubble got s=%b a=%b required s=0 a=00", st, fa);
        end
        nchk++;
        if (int'(cnt) != c0 + 1) begin
            nerr++;
            $display("FAIL lu_count got=%0d required=%0d", cnt, c0 + 1);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b01 || fa !== exp_a) begin
            nerr++;
            $display("FAIL lu_fwd got=%b required=01", fa);
        end
    endtask

    task automatic test_x0_gating();
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 13, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00) begin
            nerr++;
            $display("FAIL x0_fwd got a=%b b=%b required 00 00", fa, fb);
        end
        cyc(1, 1, 1, 9, 0, 0, 0);
        cyc(1, 9, 9, 14, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00) begin
            nerr++;
            $display("FAIL norw_fwd got a=%b b=%b required 00 00", fa, fb);
        end
        cyc(1, 1, 1, 0, 1, 1, 0);
        cyc(1, 0, 0, 15, 1, 0, 0);
        nchk++;
        if (st !== 1'b0) begin
            nerr++;
            $display("FAIL x0_stall got=%b required=0", st);
        end
    endtask

    task automatic test_flush();
        cyc(1, 1, 1, 4, 1, 0, 1);
        cyc(1, 4, 4, 16, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00) begin
            nerr++;
            $display("FAIL flush_fwd got a=%b b=%b required 00 00", fa, fb);
        end
        cyc(1, 1, 1, 17, 1, 1, 0);
        cyc(1, 17, 0, 18, 1, 0, 1);
        nchk++;
        if (st !== 1'b1) begin
            nerr++;
            $display("FAIL flush_stall got=%b required=1", st);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b00 || st !== 1'b0) begin
            nerr++;
            $display("FAIL flush_stall_bubble got a=%b s=%b required 00 0", fa, st);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0);
            nchk++;
            if (fa !== exp_a || fb !== exp_b || st !== exp_s ||
                int'(cnt) != exp_cnt || int'(cnt_s) != exp_cnt_s) begin
                nerr++;
                $display("FAIL rand[%0d] got a=%b b=%b s=%b c=%0d cs=%0d required a=%b b=%b s=%b c=%0d cs=%0d",
                         i, fa, fb, st, cnt, cnt_s,
                         exp_a, exp_b, exp_s, exp_cnt, exp_cnt_s);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 1, 1, 1, 0);
            cyc(1, 1, 0, 2, 1, 0, 0);
            nchk++;
            if (st !== 1'b1 || int'(cnt_s) != exp_cnt_s) begin
                nerr++;
                $display("FAIL sat_step[%0d] got s=%b cs=%0d required s=1 cs=%0d",
                         i, st, cnt_s, exp_cnt_s);
            end
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (cnt_s !== 4'hF) begin
            nerr++;
            $display("FAIL sat_hold got=%0d required=15", cnt_s);
        end
        nchk++;
        if (int'(cnt) != exp_cnt) begin
            nerr++;
            $display("FAIL sat_wide got=%0d required=%0d", cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 3, 1, 0, 0);
        cyc(1, 3, 3, 19, 1, 0, 0);
        cyc(1, 3, 3, 20, 1, 0, 0);
        nchk++;
        if (fa !== 2'b10 || fb !== 2'b10) begin
            nerr++;
            $display("FAIL pre_reset got a=%b b=%b required 10 10", fa, fb);
        end
        rst = 1;
        #1;
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00 || st !== 1'b0 ||
            cnt !== 16'd0 || cnt_s !== 4'd0) begin
            nerr++;
            $display("FAIL reset_mid a=%b b=%b s=%b c=%0d cs=%0d required 00 00 0 0 0",
                     fa, fb, st, cnt, cnt_s);
        end
        repeat (2) @(posedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 0;
        model_reset();
        cyc(1, 3, 3, 21, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (fa !== 2'b00 || fb !== 2'b00) begin
            nerr++;
            $display("FAIL post_reset got a=%b b=%b required 00 00", fa, fb);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_x0_gating();
        test_flush();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
